// File: rtl/al_redirect_ctrl_if.sv
// Fetch-side redirect handshake between al_redirect_ctrl (master) and the PC/fetch unit (slave).
// jumpEnOut/jumpAddrOut form a valid/data pair; redirRdyIn accepts the pending redirect.
interface al_redirect_ctrl_if #(
  parameter int BUS_W = 32
) ();
  logic             jumpEnOut;
  logic [BUS_W-1:0] jumpAddrOut;
  logic             redirRdyIn;

  modport master (
    output jumpEnOut,
    output jumpAddrOut,
    input  redirRdyIn
  );

  modport slave (
    input  jumpEnOut,
    input  jumpAddrOut,
    output redirRdyIn
  );
endinterface

// File: rtl/al_redirect_ctrl.sv
// Front-end redirect controller: arbitrates EX branch vs ID JALR/JAL, drives flushes, holds the redirect to fetch.
// Optional misaligned-target trap enabled by defining RVX_JUMP_MISALIGN_EN.
module al_redirect_ctrl #(
  parameter int BUS_W  = 32,
  parameter int NSTAGE = 2,
  parameter int CNT_W  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [31:0]           instIn_IFID,
  input  logic                  branchTaken_EX,
  input  logic [BUS_W-1:0]      pcPlusImmIn_IDEX,
  input  logic [BUS_W-1:0]      pcPlusImmIn_ID,
  input  logic [BUS_W-1:0]      pcPlusRegData1In_ID,
  al_redirect_ctrl_if.master    fetch,
  output logic [NSTAGE-1:0]     flushOut,
  output logic                  busyOut,
  output logic                  misalignOut,
  output logic [CNT_W-1:0]      redirCntOut
);

  localparam logic [6:0] OP_J  = 7'b1101111;
  localparam logic [6:0] OP_IJ = 7'b1100111;

  typedef enum logic {
    IDLE,
    PEND
  } state_t;

  // Ordered so that a plain magnitude compare gives "strictly higher priority".
  typedef enum logic [1:0] {
    PRIO_NONE = 2'd0,
    PRIO_JAL  = 2'd1,
    PRIO_JALR = 2'd2,
    PRIO_EX   = 2'd3
  } prio_t;

  state_t           state_q, state_d;
  prio_t            prio_q;
  prio_t            req_prio;
  logic [BUS_W-1:0] req_addr;
  logic [BUS_W-1:0] addr_q;
  logic [CNT_W-1:0] cnt_q;
  logic             req_valid;
  logic             req_misalign;
  logic             take;
  logic             accept;
  logic             misalign_d, misalign_q;
  logic             unused_inst;

  assign unused_inst = ^instIn_IFID[31:7];

  // NOTE: every variable written in always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    req_prio = PRIO_NONE;
    req_addr = '0;
    if (branchTaken_EX) begin
      req_prio = PRIO_EX;
      req_addr = pcPlusImmIn_IDEX;
    end else if (instIn_IFID[6:0] == OP_IJ) begin
      req_prio = PRIO_JALR;
      req_addr = {pcPlusRegData1In_ID[BUS_W-1:1], 1'b0};
    end else if (instIn_IFID[6:0] == OP_J) begin
      req_prio = PRIO_JAL;
      req_addr = pcPlusImmIn_ID;
    end
  end

  assign req_valid = (req_prio != PRIO_NONE);

`ifdef RVX_JUMP_MISALIGN_EN
  assign req_misalign = req_addr[1];
`else
  assign req_misalign = 1'b0;
`endif

  // Next-state logic. While a redirect is stalled, only a strictly higher-priority
  // source may replace it; anything else is on the wrong path and is dropped.
  always_comb begin
    state_d    = state_q;
    take       = 1'b0;
    accept     = 1'b0;
    misalign_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        take = req_valid;
      end
      PEND: begin
        accept = fetch.redirRdyIn;
        take   = req_valid && (fetch.redirRdyIn || (req_prio > prio_q));
        if (fetch.redirRdyIn) state_d = IDLE;
      end
    endcase
    if (take) begin
      if (req_misalign) begin
        misalign_d = 1'b1;
        state_d    = IDLE;
      end else begin
        state_d    = PEND;
      end
    end
  end

  always_comb begin
    flushOut = '0;
    if (take) begin
      if (req_prio == PRIO_EX) flushOut = '1;
      else                     flushOut = NSTAGE'(1);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // NOTE: the captured target is reset too, so jumpAddrOut is a clean zero straight out of reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      addr_q     <= '0;
      prio_q     <= PRIO_NONE;
      misalign_q <= 1'b0;
      cnt_q      <= '0;
    end else begin
      misalign_q <= misalign_d;
      if (take) begin
        addr_q <= req_addr;
        prio_q <= req_prio;
      end
      if (accept) cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign fetch.jumpEnOut   = (state_q == PEND);
  assign fetch.jumpAddrOut = ((state_q == PEND) || misalign_q) ? addr_q : '0;
  assign busyOut           = (state_q == PEND);
  assign misalignOut       = misalign_q;
  assign redirCntOut       = cnt_q;

endmodule

// File: tb/tb_al_redirect_ctrl.sv
// Self-checking bench for al_redirect_ctrl: scenario tasks plus an accepted-redirect scoreboard.
// A second instance (NSTAGE=4, CNT_W=3) covers the wide flush vector and counter wrap.
module tb_al_redirect_ctrl;

  localparam logic [31:0] I_JAL  = 32'h0000_006F;
  localparam logic [31:0] I_JALR = 32'h0000_0067;
  localparam logic [31:0] I_NOP  = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] instr;
  logic        br;
  logic [31:0] pc_ex, pc_jal, pc_jalr;

  logic [1:0]  flush;
  logic        busy, mis;
  logic [15:0] cnt;
  logic [3:0]  flush4;
  logic        busy4, mis4;
  logic [2:0]  cnt4;

  int          vectors     = 0;
  int          miscompares = 0;
  int          total_acc   = 0;
  logic [31:0] sb[$];

  al_redirect_ctrl_if #(.BUS_W(32)) rif ();
  al_redirect_ctrl_if #(.BUS_W(32)) rif4 ();

  assign rif4.redirRdyIn = rif.redirRdyIn;

  al_redirect_ctrl #(.BUS_W(32), .NSTAGE(2), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .instIn_IFID(instr), .branchTaken_EX(br),
    .pcPlusImmIn_IDEX(pc_ex), .pcPlusImmIn_ID(pc_jal), .pcPlusRegData1In_ID(pc_jalr),
    .fetch(rif), .flushOut(flush), .busyOut(busy), .misalignOut(mis), .redirCntOut(cnt)
  );

  al_redirect_ctrl #(.BUS_W(32), .NSTAGE(4), .CNT_W(3)) dut4 (
    .clk(clk), .rst(rst), .instIn_IFID(instr), .branchTaken_EX(br),
    .pcPlusImmIn_IDEX(pc_ex), .pcPlusImmIn_ID(pc_jal), .pcPlusRegData1In_ID(pc_jalr),
    .fetch(rif4), .flushOut(flush4), .busyOut(busy4), .misalignOut(mis4), .redirCntOut(cnt4)
  );

  always #5 clk = ~clk;

  // Scoreboard: every acceptance seen at fetch must match the next expected target.
  always @(negedge clk) begin : monitor
    logic [31:0] exp_addr;
    if (rst === 1'b1 && rif.jumpEnOut === 1'b1 && rif.redirRdyIn === 1'b1) begin
      vectors++;
      if (sb.size() == 0) begin
        miscompares++;
        $display("FAIL accept_unexpected: got addr %h, expected no acceptance", rif.jumpAddrOut);
      end else begin
        exp_addr = sb.pop_front();
        if (rif.jumpAddrOut !== exp_addr) begin
          miscompares++;
          $display("FAIL accept_addr: got %h, expected %h", rif.jumpAddrOut, exp_addr);
        end
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic samp;
    @(negedge clk);
  endtask

  task automatic test_reset;
    rst = 1'b0; br = 1'b1; pc_ex = 32'h123; instr = I_NOP;
    pc_jal = '0; pc_jalr = '0; rif.redirRdyIn = 1'b0;
    #2;
    vectors++; if (rif.jumpEnOut !== 1'b0) begin miscompares++; $display("FAIL rst_jump_en: got %b, expected 0", rif.jumpEnOut); end
    vectors++; if (cnt !== 16'd0) begin miscompares++; $display("FAIL rst_cnt: got %0d, expected 0", cnt); end
    vectors++; if (flush !== 2'b11) begin miscompares++; $display("FAIL rst_flush: got %b, expected 11", flush); end
    vectors++; if (rif.jumpAddrOut !== 32'h0 || busy !== 1'b0 || mis !== 1'b0) begin
      miscompares++; $display("FAIL rst_outs: addr %h busy %b mis %b, expected 0/0/0", rif.jumpAddrOut, busy, mis);
    end
    samp;
    vectors++; if (rif.jumpEnOut !== 1'b0) begin miscompares++; $display("FAIL rst_edge_jump_en: got %b, expected 0", rif.jumpEnOut); end
    tick; br = 1'b0; rst = 1'b1;
    samp;
    vectors++; if (rif.jumpEnOut !== 1'b0 || flush !== 2'b00) begin
      miscompares++; $display("FAIL rst_release: jumpEn %b flush %b, expected 0/00", rif.jumpEnOut, flush);
    end
  endtask

  task automatic test_jalr;
    tick; instr = I_JALR; pc_jalr = 32'h0000_1005; rif.redirRdyIn = 1'b1; sb.push_back(32'h0000_1004);
    samp;
    vectors++; if (flush !== 2'b01 || rif.jumpEnOut !== 1'b0) begin
      miscompares++; $display("FAIL jalr_req: flush %b jumpEn %b, expected 01/0", flush, rif.jumpEnOut);
    end
    tick; instr = I_NOP;
    samp;
    vectors++; if (rif.jumpEnOut !== 1'b1 || rif.jumpAddrOut !== 32'h0000_1004 || busy !== 1'b1) begin
      miscompares++; $display("FAIL jalr_redirect: jumpEn %b addr %h busy %b, expected 1/00001004/1", rif.jumpEnOut, rif.jumpAddrOut, busy);
    end
    total_acc++;
    tick; rif.redirRdyIn = 1'b0;
    samp;
    vectors++; if (rif.jumpEnOut !== 1'b0 || cnt !== 16'(total_acc)) begin
      miscompares++; $display("FAIL jalr_done: jumpEn %b cnt %0d, expected 0/%0d", rif.jumpEnOut, cnt, total_acc);
    end
  endtask

  task automatic test_override;
    tick; instr = I_JAL; pc_jal = 32'h200; rif.redirRdyIn = 1'b0;
    samp;
    vectors++; if (flush !== 2'b01) begin miscompares++; $display("FAIL ovr_jal_flush: got %b, expected 01", flush); end
    tick; instr = I_NOP;
    samp;
    vectors++; if (rif.jumpEnOut !== 1'b1 || rif.jumpAddrOut !== 32'h200) begin
      miscompares++; $display("FAIL ovr_pend: jumpEn %b addr %h, expected 1/00000200", rif.jumpEnOut, rif.jumpAddrOut);
    end
    tick; br = 1'b1; pc_ex = 32'h300;
    samp;
    vectors++; if (flush !== 2'b11 || rif.jumpAddrOut !== 32'h200) begin
      miscompares++; $display("FAIL ovr_ex_req: flush %b addr %h, expected 11/00000200", flush, rif.jumpAddrOut);
    end
    tick; br = 1'b0; rif.redirRdyIn = 1'b1; sb.push_back(32'h300);
    samp;
    vectors++; if (rif.jumpEnOut !== 1'b1 || rif.jumpAddrOut !== 32'h300) begin
      miscompares++; $display("FAIL ovr_switch: jumpEn %b addr %h, expected 1/00000300", rif.jumpEnOut, rif.jumpAddrOut);
    end
    total_acc++;
    tick; rif.redirRdyIn = 1'b0;
    samp;
    vectors++; if (rif.jumpEnOut !== 1'b0 || cnt !== 16'(total_acc)) begin
      miscompares++; $display("FAIL ovr_done: jumpEn %b cnt %0d, expected 0/%0d", rif.jumpEnOut, cnt, total_acc);
    end
  endtask

  task automatic test_ignore;
    tick; br = 1'b1; pc_ex = 32'h400; rif.redirRdyIn = 1'b0;
    samp;
    vectors++; if (flush !== 2'b11) begin miscompares++; $display("FAIL ign_ex_flush: got %b, expected 11", flush); end
    tick; br = 1'b0; instr = I_JAL; pc_jal = 32'h500;
    samp;
    vectors++; if (flush !== 2'b00 || rif.jumpAddrOut !== 32'h400) begin
      miscompares++; $display("FAIL ign_jal: flush %b addr %h, expected 00/00000400", flush, rif.jumpAddrOut);
    end
    tick; instr = I_NOP; rif.redirRdyIn = 1'b1; sb.push_back(32'h400);
    samp;
    vectors++; if (rif.jumpEnOut !== 1'b1 || rif.jumpAddrOut !== 32'h400) begin
      miscompares++; $display("FAIL ign_hold: jumpEn %b addr %h, expected 1/00000400", rif.jumpEnOut, rif.jumpAddrOut);
    end
    total_acc++;
    tick; rif.redirRdyIn = 1'b0;
    samp;
    vectors++; if (rif.jumpEnOut !== 1'b0) begin miscompares++; $display("FAIL ign_done: jumpEn %b, expected 0", rif.jumpEnOut); end
  endtask

  task automatic test_same_cycle;
    tick; br = 1'b1; pc_ex = 32'h600; instr = I_JAL; pc_jal = 32'h700; rif.redirRdyIn = 1'b1; sb.push_back(32'h600);
    samp;
    vectors++; if (flush !== 2'b11) begin miscompares++; $display("FAIL same_flush2: got %b, expected 11", flush); end
    vectors++; if (flush4 !== 4'b1111) begin miscompares++; $display("FAIL same_flush4: got %b, expected 1111", flush4); end
    tick; br = 1'b0; instr = I_NOP;
    samp;
    vectors++; if (rif.jumpAddrOut !== 32'h600 || rif4.jumpAddrOut !== 32'h600) begin
      miscompares++; $display("FAIL same_target: addr %h addr4 %h, expected 00000600", rif.jumpAddrOut, rif4.jumpAddrOut);
    end
    total_acc++;
    tick; rif.redirRdyIn = 1'b0;
    samp;
    vectors++; if (rif.jumpEnOut !== 1'b0) begin miscompares++; $display("FAIL same_done: jumpEn %b, expected 0", rif.jumpEnOut); end
  endtask

  task automatic test_back_to_back;
    logic [31:0] exp_addr;
    for (int k = 0; k <= 4; k++) begin
      tick;
      rif.redirRdyIn = 1'b1;
      if (k < 4) begin
        instr = I_JAL; pc_jal = 32'h800 + 32'(k) * 32'h10; sb.push_back(pc_jal);
      end else begin
        instr = I_NOP;
      end
      samp;
      if (k < 4) begin
        vectors++; if (flush !== 2'b01) begin miscompares++; $display("FAIL b2b_flush[%0d]: got %b, expected 01", k, flush); end
      end
      if (k > 0) begin
        exp_addr = 32'h800 + 32'(k - 1) * 32'h10;
        vectors++; if (rif.jumpEnOut !== 1'b1 || rif.jumpAddrOut !== exp_addr) begin
          miscompares++; $display("FAIL b2b_addr[%0d]: jumpEn %b addr %h, expected 1/%h", k, rif.jumpEnOut, rif.jumpAddrOut, exp_addr);
        end
      end
    end
    total_acc += 4;
    tick; rif.redirRdyIn = 1'b0;
    samp;
    vectors++; if (rif.jumpEnOut !== 1'b0 || cnt !== 16'(total_acc)) begin
      miscompares++; $display("FAIL b2b_done: jumpEn %b cnt %0d, expected 0/%0d", rif.jumpEnOut, cnt, total_acc);
    end
  endtask

  task automatic test_misalign;
    tick; instr = I_JAL; pc_jal = 32'h102; rif.redirRdyIn = 1'b1;
`ifndef RVX_JUMP_MISALIGN_EN
    sb.push_back(32'h102);
`endif
    samp;
    vectors++; if (flush !== 2'b01) begin miscompares++; $display("FAIL mis_flush: got %b, expected 01", flush); end
    tick; instr = I_NOP;
    samp;
`ifdef RVX_JUMP_MISALIGN_EN
    vectors++; if (mis !== 1'b1 || rif.jumpEnOut !== 1'b0 || rif.jumpAddrOut !== 32'h102) begin
      miscompares++; $display("FAIL mis_pulse: mis %b jumpEn %b addr %h, expected 1/0/00000102", mis, rif.jumpEnOut, rif.jumpAddrOut);
    end
`else
    vectors++; if (mis !== 1'b0 || rif.jumpEnOut !== 1'b1 || rif.jumpAddrOut !== 32'h102) begin
      miscompares++; $display("FAIL mis_redirect: mis %b jumpEn %b addr %h, expected 0/1/00000102", mis, rif.jumpEnOut, rif.jumpAddrOut);
    end
    total_acc++;
`endif
    tick; rif.redirRdyIn = 1'b0;
    samp;
    vectors++; if (mis !== 1'b0 || rif.jumpEnOut !== 1'b0 || cnt !== 16'(total_acc)) begin
      miscompares++; $display("FAIL mis_after: mis %b jumpEn %b cnt %0d, expected 0/0/%0d", mis, rif.jumpEnOut, cnt, total_acc);
    end
  endtask

  task automatic test_cnt_wrap;
    logic [2:0] exp_cnt4;
    exp_cnt4 = 3'(total_acc % 8);
    vectors++; if (cnt4 !== exp_cnt4) begin
      miscompares++; $display("FAIL cnt_wrap: got %0d, expected %0d after %0d accepts", cnt4, exp_cnt4, total_acc);
    end
  endtask

  task automatic test_reset_mid_pend;
    tick; br = 1'b1; pc_ex = 32'h900; rif.redirRdyIn = 1'b0;
    samp;
    vectors++; if (flush !== 2'b11) begin miscompares++; $display("FAIL rmid_flush: got %b, expected 11", flush); end
    tick; br = 1'b0;
    samp;
    vectors++; if (rif.jumpEnOut !== 1'b1 || busy !== 1'b1) begin
      miscompares++; $display("FAIL rmid_pend: jumpEn %b busy %b, expected 1/1", rif.jumpEnOut, busy);
    end
    #2 rst = 1'b0;
    #1;
    vectors++; if (rif.jumpEnOut !== 1'b0 || busy !== 1'b0 || rif.jumpAddrOut !== 32'h0 || cnt !== 16'd0 || mis !== 1'b0) begin
      miscompares++; $display("FAIL rmid_async: jumpEn %b busy %b addr %h cnt %0d mis %b, expected all 0",
                              rif.jumpEnOut, busy, rif.jumpAddrOut, cnt, mis);
    end
    tick; rst = 1'b1; rif.redirRdyIn = 1'b1;
    samp;
    vectors++; if (rif.jumpEnOut !== 1'b0) begin miscompares++; $display("FAIL rmid_dropped: jumpEn %b, expected 0", rif.jumpEnOut); end
    tick; rif.redirRdyIn = 1'b0;
    samp;
    vectors++; if (cnt !== 16'd0) begin miscompares++; $display("FAIL rmid_cnt: got %0d, expected 0", cnt); end
  endtask

  initial begin
    test_reset;
    test_jalr;
    test_override;
    test_ignore;
    test_same_cycle;
    test_back_to_back;
    test_misalign;
    test_cnt_wrap;
    test_reset_mid_pend;
    vectors++;
    if (sb.size() != 0) begin
      miscompares++; $display("FAIL sb_drain: %0d expected redirects never accepted", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
